// File: rtl/cmd_aggregator_pkg.sv
// Shared types and widths for the command aggregator slice.
// Optional feature macro used by this slice: CMD_TIMEOUT_EN.
package cmd_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned STAGE_W = 16;
  localparam int unsigned CMD_W   = 24;

  typedef enum logic [1:0] {
    AGG_B0,
    AGG_B1,
    AGG_B2
  } AggState;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } TxState;

  // Command payload in wire order: first received byte is the most significant.
  typedef struct packed {
    logic [BYTE_W-1:0] b0;
    logic [BYTE_W-1:0] b1;
    logic [BYTE_W-1:0] b2;
  } cmd_bytes_t;

  function automatic logic [CMD_W-1:0] pack_cmd(input logic [STAGE_W-1:0] stage,
                                                input logic [BYTE_W-1:0]  last);
    cmd_bytes_t c;
    c.b0 = stage[STAGE_W-1:BYTE_W];
    c.b1 = stage[BYTE_W-1:0];
    c.b2 = last;
    return c;
  endfunction

endpackage

// File: rtl/cmd_aggregator_if.sv
// UART-side and command-side signal bundle of cmd_aggregator.
// master = environment (UART, cmd_module); slave = cmd_aggregator.
interface cmd_aggregator_if;
  import cmd_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_rdy;
  logic              clr_rx_rdy;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_rdy;
  logic              clr_cmd_rdy;
  logic              cmd_ovr;
  logic              cmd_timeout;
  logic [BYTE_W-1:0] resp_data;
  logic              send_resp;
  logic              resp_full;
  logic              resp_ovr;
  logic [BYTE_W-1:0] tx_data;
  logic              trmt;
  logic              tx_done;

  modport master (
    output rx_data, rx_rdy, clr_cmd_rdy, resp_data, send_resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy, cmd_ovr, cmd_timeout,
           resp_full, resp_ovr, tx_data, trmt
  );

  modport slave (
    input  rx_data, rx_rdy, clr_cmd_rdy, resp_data, send_resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, cmd_ovr, cmd_timeout,
           resp_full, resp_ovr, tx_data, trmt
  );

endinterface

// File: rtl/cmd_aggregator_resp_fifo.sv
// Response byte FIFO: wrap-around pointers, occupancy counter, flags decoded from count.
// A push while full is accepted only when a pop happens in the same cycle.
module resp_fifo #(
  parameter int unsigned RESP_DEPTH = 8,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(RESP_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              wr_en;
  logic              rd_en;

  assign full  = (count == CNT_W'(RESP_DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  // Pointers and occupancy; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cmd_aggregator.sv
// Assembles 3 RX bytes into a 24-bit command and drains a response FIFO to UART TX.
// Define CMD_TIMEOUT_EN to discard partial commands after TIMEOUT_CYC idle cycles.
module cmd_aggregator
  import cmd_pkg::*;
#(
  parameter int unsigned RESP_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  cmd_aggregator_if.slave  bus
);

  if (RESP_DEPTH < 2 || (RESP_DEPTH & (RESP_DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("cmd_aggregator: RESP_DEPTH must be a power of 2 >= 2, TIMEOUT_CYC >= 2");
  end

  AggState            agg_state;
  logic [STAGE_W-1:0] stage;
  logic [CMD_W-1:0]   cmd_q;
  logic               cmd_rdy_q;
  logic               cmd_ovr_q;
  logic               clr_rx_q;
  logic               take;
  logic               expire;

  // A byte still flagged on the cycle after its clr_rx_rdy pulse is the same byte.
  assign take = bus.rx_rdy && !clr_rx_q;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_q;

  assign expire = (agg_state != AGG_B0) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= expire;
      if (take || expire || agg_state == AGG_B0) tmo_cnt <= '0;
      else                                       tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign bus.cmd_timeout = tmo_q;
`else
  assign expire          = 1'b0;
  assign bus.cmd_timeout = 1'b0;
`endif

  // Aggregator FSM with command handshake and overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      agg_state <= AGG_B0;
      stage     <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
      cmd_ovr_q <= 1'b0;
      clr_rx_q  <= 1'b0;
    end else begin
      clr_rx_q <= take;
      if (bus.clr_cmd_rdy) cmd_rdy_q <= 1'b0;
      if (take) begin
        if (expire) begin
          // Byte arriving on the expiry cycle starts a fresh command.
          stage     <= {bus.rx_data, BYTE_W'(0)};
          agg_state <= AGG_B1;
        end else begin
          case (agg_state)
            AGG_B0: begin
              stage[STAGE_W-1:BYTE_W] <= bus.rx_data;
              agg_state               <= AGG_B1;
            end
            AGG_B1: begin
              stage[BYTE_W-1:0] <= bus.rx_data;
              agg_state         <= AGG_B2;
            end
            AGG_B2: begin
              agg_state <= AGG_B0;
              if (cmd_rdy_q && !bus.clr_cmd_rdy) begin
                cmd_ovr_q <= 1'b1;
              end else begin
                cmd_q     <= pack_cmd(stage, bus.rx_data);
                cmd_rdy_q <= 1'b1;
              end
            end
            default: agg_state <= AGG_B0;
          endcase
        end
      end else if (expire) begin
        agg_state <= AGG_B0;
        stage     <= '0;
      end
    end
  end

  assign bus.clr_rx_rdy = clr_rx_q;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.cmd_ovr    = cmd_ovr_q;

  TxState            tx_state;
  logic [BYTE_W-1:0] tx_data_q;
  logic              trmt_q;
  logic              resp_ovr_q;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_head;

  // The head stays in the FIFO while it is on the wire and is popped on tx_done.
  assign fifo_pop = (tx_state == TX_BUSY) && bus.tx_done;

  resp_fifo #(
    .RESP_DEPTH (RESP_DEPTH),
    .DATA_W     (BYTE_W)
  ) u_resp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.send_resp),
    .pop   (fifo_pop),
    .din   (bus.resp_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // TX FSM and response overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state   <= TX_IDLE;
      tx_data_q  <= '0;
      trmt_q     <= 1'b0;
      resp_ovr_q <= 1'b0;
    end else begin
      trmt_q <= 1'b0;
      if (bus.send_resp && fifo_full && !fifo_pop) resp_ovr_q <= 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            tx_data_q <= fifo_head;
            trmt_q    <= 1'b1;
            tx_state  <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (bus.tx_done) tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.trmt      = trmt_q;
  assign bus.resp_full = fifo_full;
  assign bus.resp_ovr  = resp_ovr_q;

endmodule
